// File: rtl/clk_div_bank_pkg.sv
// Purpose: shared constants and mode encoding for the clock/tick divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_bank_pkg;

   // Per-channel output mode: free-running 50% clock or one-cycle strobe.
   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_STROBE = 1'b1
   } mode_e;

   // 0.5 s at a 50 MHz oscillator.
   localparam int DEFAULT_DIV_C = 25_000_000;

   // Short divisors so simulations reach many terminal counts quickly.
   localparam int SIM_DIV      = 3;
   localparam int SIM_DIV_SLOW = 5;

endpackage

// File: rtl/clk_div_bank_if.sv
// Purpose: control/status bundle of the divider bank (enables, modes, divisor write port, outputs).
// Latency: n/a (wiring only).
// Backpressure: div_rdy gates divisor writes; all other signals are unconditioned levels.
interface clk_div_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27,
   parameter int SEL_W  = 2
);
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] mode;
   logic              sync_clr;
   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_val;
   logic              div_rdy;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   // master: whoever programs the bank; slave: the bank itself.
   modport master (
      output ch_en, mode, sync_clr, div_wr, div_sel, div_val,
      input  div_rdy, clk_out, tick
   );

   modport slave (
      input  ch_en, mode, sync_clr, div_wr, div_sel, div_val,
      output div_rdy, clk_out, tick
   );
endinterface

// File: rtl/clk_div_bank_ch.sv
// Purpose: one divider channel; counter, active/shadow divisor, toggle-or-strobe output.
// Latency: tick/clk_out registered, 1 cycle after the counter reaches d-1.
// Backpressure: pending flags an unapplied shadow divisor; the parent must not write while it is set.
// Ports: clk/rst, en, mode, sync_clr, wr + wr_val (already-accepted write), pending, clk_out, tick.
module clk_div_bank_ch
   import clk_div_bank_pkg::*;
#(
   parameter int               CNT_W       = 27,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             sync_clr,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_val,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] d_eff;
   logic             tc;
   // Mode in force for the current period; a new mode is only adopted at TC
   // so a mid-period change never chops the clock.
   logic             mode_q;

   // A programmed divisor of 0 behaves as 1.
   assign d_eff = (div_q == '0) ? CNT_W'(1) : div_q;
   assign tc    = en && (cnt == d_eff - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         div_q   <= DEFAULT_DIV;
         shadow  <= DEFAULT_DIV;
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         mode_q  <= 1'b0;
      end else if (sync_clr) begin
         // Phase align: everything restarts, and any outstanding divisor
         // (a same-cycle write wins, being the newest) takes effect now.
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         mode_q  <= mode;
         pending <= 1'b0;
         if (wr)
            div_q <= wr_val;
         else if (pending)
            div_q <= shadow;
      end else if (!en) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         mode_q  <= mode;
         // Idle channel has no period to protect: apply the shadow next cycle.
         if (wr) begin
            shadow  <= wr_val;
            pending <= 1'b1;
         end else if (pending) begin
            div_q   <= shadow;
            pending <= 1'b0;
         end
      end else begin
         tick <= tc;
         if (tc) begin
            cnt     <= '0;
            mode_q  <= mode;
            clk_out <= (mode == MODE_STROBE) ? 1'b1 : ~clk_out;
            // Old shadow lands at this boundary; a write accepted on the
            // same edge becomes the next pending value.
            if (pending)
               div_q <= shadow;
            pending <= wr;
            if (wr)
               shadow <= wr_val;
         end else begin
            cnt <= cnt + CNT_W'(1);
            if (mode_q == MODE_STROBE)
               clk_out <= 1'b0;
            if (wr) begin
               shadow  <= wr_val;
               pending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Purpose: NUM_CH-channel clock/tick divider bank with glitch-free runtime divisor updates.
// Latency: outputs registered, 1 cycle after each channel's terminal count.
// Backpressure: div_rdy low while the selected channel holds an unapplied divisor or div_sel is out of range.
// Ports: clk_osc, RESET (async, active high), reset (pass-through), bus (clk_div_bank_if.slave).
module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C,
   parameter int SEL_W       = 2
) (
   input  logic             clk_osc,
   input  logic             RESET,
   output logic             reset,
   clk_div_bank_if.slave    bus
);

   logic [NUM_CH-1:0]     pending;
   // Select space padded with permanently-busy slots so out-of-range
   // selects read as not ready and can never be accepted.
   logic [2**SEL_W-1:0]   busy;
   logic                  accept;

   always_comb begin
      busy               = '1;
      busy[NUM_CH-1:0]   = pending;
   end

   assign bus.div_rdy = ~busy[bus.div_sel];
   assign accept      = bus.div_wr & bus.div_rdy;
   assign reset       = RESET;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_bank_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
      ) u_ch (
         .clk      (clk_osc),
         .rst      (RESET),
         .en       (bus.ch_en[i]),
         .mode     (bus.mode[i]),
         .sync_clr (bus.sync_clr),
         .wr       (accept && (bus.div_sel == SEL_W'(i))),
         .wr_val   (bus.div_val),
         .pending  (pending[i]),
         .clk_out  (bus.clk_out[i]),
         .tick     (bus.tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Purpose: self-checking bench for clk_div_bank, countdown-based reference model plus literal checkpoints.
// Latency: model checked 1 ns after every rising edge.
// Backpressure: model predicts div_rdy and only credits writes it would accept.
module tb_clk_div_bank;
   import clk_div_bank_pkg::*;

   localparam int NCH = 4;
   localparam int CW  = 27;
   localparam int SW  = 3;

   logic clk_osc = 1'b0;
   logic RESET   = 1'b1;
   logic reset_o;

   clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) bus ();

   clk_div_bank #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .DEFAULT_DIV (SIM_DIV),
      .SEL_W       (SW)
   ) dut (
      .clk_osc (clk_osc),
      .RESET   (RESET),
      .reset   (reset_o),
      .bus     (bus)
   );

   always #5 clk_osc = ~clk_osc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dut=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each channel counts down the edges left until its
   // next terminal count (0 = reload from the divisor on the next enabled edge).
   int m_div [NCH];
   int m_sh  [NCH];
   int m_rem [NCH];
   bit m_pend[NCH];
   bit m_out [NCH];
   bit m_tick[NCH];
   bit m_smode[NCH];

   function automatic int deff(input int x);
      return (x == 0) ? 1 : x;
   endfunction

   function automatic bit m_rdy(input int sel);
      return (sel < NCH) ? !m_pend[sel] : 1'b0;
   endfunction

   task automatic model_step();
      bit acc;
      bit wr, en, md;
      int val;
      if (RESET) begin
         for (int c = 0; c < NCH; c++) begin
            m_div[c] = SIM_DIV; m_sh[c] = SIM_DIV; m_rem[c] = 0;
            m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_smode[c] = 0;
         end
         return;
      end
      acc = bus.div_wr && m_rdy(int'(bus.div_sel));
      val = int'(bus.div_val);
      for (int c = 0; c < NCH; c++) begin
         wr = acc && (int'(bus.div_sel) == c);
         en = bus.ch_en[c];
         md = bus.mode[c];
         if (bus.sync_clr) begin
            if (wr)          m_div[c] = val;
            else if (m_pend[c]) m_div[c] = m_sh[c];
            m_pend[c] = 0; m_rem[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_smode[c] = md;
         end else if (!en) begin
            m_rem[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_smode[c] = md;
            if (wr) begin m_sh[c] = val; m_pend[c] = 1; end
            else if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
         end else begin
            if (m_rem[c] == 0) m_rem[c] = deff(m_div[c]);
            if (m_rem[c] == 1) begin
               m_tick[c] = 1;
               if (m_pend[c]) m_div[c] = m_sh[c];
               m_pend[c] = wr;
               if (wr) m_sh[c] = val;
               m_out[c]   = md ? 1'b1 : !m_out[c];
               m_smode[c] = md;
               m_rem[c]   = 0;
            end else begin
               m_tick[c] = 0;
               m_rem[c]  = m_rem[c] - 1;
               if (m_smode[c]) m_out[c] = 0;
               if (wr) begin m_sh[c] = val; m_pend[c] = 1; end
            end
         end
      end
   endtask

   // Compare process: every cycle, after the edge has settled.
   initial begin
      logic [NCH-1:0] e_out, e_tick;
      forever begin
         @(posedge clk_osc);
         #1;
         model_step();
         for (int c = 0; c < NCH; c++) begin
            e_out[c]  = m_out[c];
            e_tick[c] = m_tick[c];
         end
         check("model_clk_out", bus.clk_out, e_out);
         check("model_tick",    bus.tick,    e_tick);
         check("model_div_rdy", bus.div_rdy, m_rdy(int'(bus.div_sel)));
         check("model_reset",   reset_o,     RESET);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_osc);
   endtask

   // Directed stimulus with hand-computed checkpoints.
   initial begin
      bus.ch_en = '0; bus.mode = '0; bus.sync_clr = 0;
      bus.div_wr = 0; bus.div_sel = '0; bus.div_val = '0;
      RESET = 1;
      cyc(2);
      RESET = 0;
      check("rst_clk_out", bus.clk_out, 0);
      check("rst_tick",    bus.tick,    0);
      check("rst_rdy",     bus.div_rdy, 1);

      // ch0 toggle at default divisor 3
      bus.ch_en = 4'b0001;
      cyc(3);
      check("ch0_tc1_tick", bus.tick,    4'b0001);
      check("ch0_tc1_clk",  bus.clk_out, 4'b0001);
      cyc(1);
      check("ch0_gap_tick", bus.tick,    4'b0000);
      check("ch0_gap_clk",  bus.clk_out, 4'b0001);
      cyc(2);
      check("ch0_tc2_tick", bus.tick,    4'b0001);
      check("ch0_tc2_clk",  bus.clk_out, 4'b0000);
      cyc(6);

      // ch1 strobe; divisor 5 written mid-period, second write dropped
      bus.mode = 4'b0010; bus.ch_en = 4'b0011;
      cyc(1);
      bus.div_sel = 3'd1; bus.div_val = 5; bus.div_wr = 1;
      cyc(1);
      check("ch1_rdy_pending", bus.div_rdy, 0);
      bus.div_val = 7;
      cyc(1);
      bus.div_wr = 0;
      check("ch1_old_period_tick", bus.tick[1], 1);
      check("ch1_rdy_after_swap",  bus.div_rdy, 1);
      cyc(5);
      check("ch1_new_tc1", bus.tick[1], 1);
      check("ch1_new_clk", bus.clk_out[1], 1);
      cyc(1);
      check("ch1_new_gap", bus.tick[1], 0);
      cyc(4);
      check("ch1_new_tc2", bus.tick[1], 1);

      // out-of-range select is never ready and has no effect
      bus.div_sel = 3'd5; bus.div_val = 9; bus.div_wr = 1;
      #1;
      check("oob_rdy", bus.div_rdy, 0);
      cyc(1);
      bus.div_wr = 0;

      // ch2 divisor 0 (acts as 1), toggle then strobe
      bus.div_sel = 3'd2; bus.div_val = 0; bus.div_wr = 1;
      cyc(1);
      bus.div_wr = 0;
      cyc(1);
      bus.ch_en = 4'b0111;
      cyc(1);
      check("ch2_d1_clk_hi", bus.clk_out[2], 1);
      check("ch2_d1_tick",   bus.tick[2],    1);
      cyc(1);
      check("ch2_d1_clk_lo", bus.clk_out[2], 0);
      cyc(4);
      bus.mode = 4'b0110;
      cyc(2);
      check("ch2_strobe_clk",  bus.clk_out[2], 1);
      check("ch2_strobe_tick", bus.tick[2],    1);
      cyc(3);

      // ch3 divisor 4, all running, then sync_clr with a same-cycle write of 2 to ch0
      bus.div_sel = 3'd3; bus.div_val = 4; bus.div_wr = 1;
      cyc(1);
      bus.div_wr = 0;
      cyc(1);
      bus.ch_en = 4'b1111;
      cyc(7);
      bus.sync_clr = 1; bus.div_sel = 3'd0; bus.div_val = 2; bus.div_wr = 1;
      cyc(1);
      bus.sync_clr = 0; bus.div_wr = 0;
      check("clr_clk_out", bus.clk_out, 0);
      check("clr_tick",    bus.tick,    0);
      cyc(1);
      check("align_e1", bus.tick, 4'b0100);
      cyc(1);
      check("align_e2", bus.tick, 4'b0101);
      cyc(2);
      check("align_e4", bus.tick, 4'b1101);
      cyc(1);
      check("align_e5", bus.tick, 4'b0110);
      cyc(10);

      // asynchronous reset between edges
      #2 RESET = 1;
      #1;
      check("arst_clk_out", bus.clk_out, 0);
      check("arst_tick",    bus.tick,    0);
      check("arst_passthru", reset_o,    1);
      cyc(2);
      RESET = 0;
      bus.ch_en = 4'b0001; bus.mode = 4'b0000;
      for (int i = 0; i < NCH; i++) begin
         bus.div_sel = SW'(i);
         #1;
         check("post_rst_rdy", bus.div_rdy, 1);
      end
      bus.div_sel = 3'd0;
      cyc(3);
      check("post_rst_div3_tick", bus.tick, 4'b0001);
      cyc(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
